frame_buf_ctrl: RTL

FRAME_BUF_CTRL -- requirements
Module: frame_buf_ctrl

---
 rtl/frame_buf_ctrl_if.sv | 31 +++
 rtl/frame_buf_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_ctrl_if.sv
// Controller-side bundle for the frame buffer controller: camera/display FIFO status,
// frame toggles, the two SDRAM burst handshakes and frame status outputs.
interface frame_buf_ctrl_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              wr_fifo_ok;
  logic              wr_frame_tog;
  logic              rd_fifo_ok;
  logic              rd_frame_tog;
  logic              wr_sdram_req;
  logic              wr_sdram_ack;
  logic [ADDR_W-1:0] wr_sdram_add;
  logic              rd_sdram_req;
  logic              rd_sdram_ack;
  logic [ADDR_W-1:0] rd_sdram_add;
  logic              frame_valid;
  logic              wr_frame_done;
  logic [15:0]       drop_cnt;

  modport master (
    input  wr_fifo_ok, wr_frame_tog, rd_fifo_ok, rd_frame_tog, wr_sdram_ack, rd_sdram_ack,
    output wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add, frame_valid,
           wr_frame_done, drop_cnt
  );

  modport slave (
    output wr_fifo_ok, wr_frame_tog, rd_fifo_ok, rd_frame_tog, wr_sdram_ack, rd_sdram_ack,
    input  wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add, frame_valid,
           wr_frame_done, drop_cnt
  );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Rotating multi-buffer frame store controller: an independent camera writer and display
// reader, each issuing burst requests to SDRAM with buffer/row-encoded addresses.
module frame_buf_ctrl #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned BURST_LSB    = 9,
  parameter int unsigned BUF_LSB      = 22,
  parameter int unsigned NUM_BUF      = 3,
  parameter int unsigned FRAME_BURSTS = 750
) (
  input logic              clk_133M,
  input logic              rst_133,
  frame_buf_ctrl_if.master bus
);

  localparam int unsigned BUF_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int unsigned ROW_W = BUF_LSB - BURST_LSB;
  // One spare bit so the counter can reach FRAME_BURSTS when it equals 2^ROW_W
  localparam int unsigned CNT_W = ROW_W + 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(FRAME_BURSTS);

  if (FRAME_BURSTS > (2 ** ROW_W)) begin : g_bad_frame_bursts
    $error("FRAME_BURSTS does not fit in the row field");
  end
  if (NUM_BUF < 1 || NUM_BUF > 4) begin : g_bad_num_buf
    $error("NUM_BUF must be 1..4");
  end
  if (ADDR_W < BUF_LSB + BUF_W) begin : g_bad_addr_w
    $error("ADDR_W too narrow for buffer index");
  end

  typedef enum logic [1:0] {WIdle, WWait, WReq} wr_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RReq} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [1:0]       wr_ok_sync_q, rd_ok_sync_q;
  logic [2:0]       wr_tog_sync_q, rd_tog_sync_q;
  logic             wr_ok, rd_ok, wr_start, rd_start;
  logic [CNT_W-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d, wr_row_inc, rd_row_inc;
  logic [BUF_W-1:0] wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, last_buf_q, wr_sel, rd_src_buf;
  logic             wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic             frame_valid_q, wr_done_q, publish, wr_abort, rd_valid;
  logic [15:0]      drop_q;
  logic [ADDR_W-1:0] wr_add, rd_add;

  always_ff @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) begin
      wr_ok_sync_q  <= '0;
      rd_ok_sync_q  <= '0;
      wr_tog_sync_q <= '0;
      rd_tog_sync_q <= '0;
    end else begin
      wr_ok_sync_q  <= {wr_ok_sync_q[0], bus.wr_fifo_ok};
      rd_ok_sync_q  <= {rd_ok_sync_q[0], bus.rd_fifo_ok};
      wr_tog_sync_q <= {wr_tog_sync_q[1:0], bus.wr_frame_tog};
      rd_tog_sync_q <= {rd_tog_sync_q[1:0], bus.rd_frame_tog};
    end
  end

  assign wr_ok      = wr_ok_sync_q[1];
  assign rd_ok      = rd_ok_sync_q[1];
  assign wr_start   = wr_tog_sync_q[2] ^ wr_tog_sync_q[1];
  assign rd_start   = rd_tog_sync_q[2] ^ rd_tog_sync_q[1];
  assign wr_row_inc = wr_row_q + CNT_W'(1);
  assign rd_row_inc = rd_row_q + CNT_W'(1);

  // Lowest index clear of both reader and last frame; fallback only avoids the reader
  always_comb begin
    wr_sel = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (BUF_W'(i) != rd_buf_q) wr_sel = BUF_W'(i);
    end
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (BUF_W'(i) != rd_buf_q && BUF_W'(i) != last_buf_q) wr_sel = BUF_W'(i);
    end
  end

  // Writer FSM
  always_ff @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) wr_state_q <= WIdle;
    else          wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_row_d   = wr_row_q;
    wr_buf_d   = wr_buf_q;
    wr_pend_d  = wr_pend_q;
    publish    = 1'b0;
    wr_abort   = 1'b0;
    unique case (wr_state_q)
      WIdle: begin
        if (wr_start) begin
          wr_state_d = WWait;
          wr_buf_d   = wr_sel;
          wr_row_d   = '0;
        end
      end
      WWait: begin
        if (wr_start) begin
          wr_abort = 1'b1;
          wr_buf_d = wr_sel;
          wr_row_d = '0;
        end else if (wr_ok && wr_row_q < LAST_ROW) begin
          wr_state_d = WReq;
        end
      end
      WReq: begin
        if (bus.wr_sdram_ack) begin
          wr_pend_d = 1'b0;
          if (wr_pend_q || wr_start) begin
            wr_abort   = 1'b1;
            wr_buf_d   = wr_sel;
            wr_row_d   = '0;
            wr_state_d = WWait;
          end else begin
            wr_row_d = wr_row_inc;
            if (wr_row_inc == LAST_ROW) begin
              publish    = 1'b1;
              wr_state_d = WIdle;
            end else begin
              wr_state_d = WWait;
            end
          end
        end else if (wr_start) begin
          wr_pend_d = 1'b1;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    wr_add                        = '0;
    wr_add[BUF_LSB +: BUF_W]      = wr_buf_q;
    wr_add[BURST_LSB +: ROW_W]    = wr_row_q[ROW_W-1:0];
    bus.wr_sdram_req              = (wr_state_q == WReq);
    bus.wr_sdram_add              = wr_add;
  end

  // Reader FSM; a same-cycle publish is forwarded so the reader takes the new frame
  assign rd_src_buf = publish ? wr_buf_q : last_buf_q;
  assign rd_valid   = frame_valid_q | publish;

  always_ff @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) rd_state_q <= RIdle;
    else          rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_row_d   = rd_row_q;
    rd_buf_d   = rd_buf_q;
    rd_pend_d  = rd_pend_q;
    unique case (rd_state_q)
      RIdle: begin
        if (rd_start && rd_valid) begin
          rd_state_d = RWait;
          rd_buf_d   = rd_src_buf;
          rd_row_d   = '0;
        end
      end
      RWait: begin
        if (rd_start) begin
          rd_buf_d = rd_src_buf;
          rd_row_d = '0;
        end else if (rd_ok && rd_row_q < LAST_ROW) begin
          rd_state_d = RReq;
        end
      end
      RReq: begin
        if (bus.rd_sdram_ack) begin
          rd_pend_d = 1'b0;
          if (rd_pend_q || rd_start) begin
            rd_buf_d   = rd_src_buf;
            rd_row_d   = '0;
            rd_state_d = RWait;
          end else begin
            rd_row_d   = rd_row_inc;
            rd_state_d = (rd_row_inc == LAST_ROW) ? RIdle : RWait;
          end
        end else if (rd_start) begin
          rd_pend_d = 1'b1;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    rd_add                        = '0;
    rd_add[BUF_LSB +: BUF_W]      = rd_buf_q;
    rd_add[BURST_LSB +: ROW_W]    = rd_row_q[ROW_W-1:0];
    bus.rd_sdram_req              = (rd_state_q == RReq);
    bus.rd_sdram_add              = rd_add;
  end

  always_ff @(posedge clk_133M or negedge rst_133) begin
    if (!rst_133) begin
      wr_row_q      <= '0;
      wr_buf_q      <= '0;
      wr_pend_q     <= 1'b0;
      rd_row_q      <= '0;
      rd_buf_q      <= '0;
      rd_pend_q     <= 1'b0;
      last_buf_q    <= '0;
      frame_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      drop_q        <= '0;
    end else begin
      wr_row_q  <= wr_row_d;
      wr_buf_q  <= wr_buf_d;
      wr_pend_q <= wr_pend_d;
      rd_row_q  <= rd_row_d;
      rd_buf_q  <= rd_buf_d;
      rd_pend_q <= rd_pend_d;
      wr_done_q <= publish;
      if (publish) begin
        last_buf_q    <= wr_buf_q;
        frame_valid_q <= 1'b1;
      end
      if (wr_abort && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.frame_valid   = frame_valid_q;
  assign bus.wr_frame_done = wr_done_q;
  assign bus.drop_cnt      = drop_q;

endmodule
